// File: rtl/alu_pkg.sv
// Definitions shared by the ALU flag stage and the branch unit:
// the flag vector type, flag bit positions and condition-code encodings.
package alu_pkg;

  typedef logic [3:0] flag_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_t;

endpackage

// File: rtl/alu_flag_stage_if.sv
// Op handshake toward the flag stage (in_*) and registered op toward writeback (out_*).
interface alu_flag_stage_if #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_n;
  logic             in_z;
  logic             in_c;
  logic             in_v;
  logic             in_set_flags;
  logic [3:0]       in_cond;
  logic             in_wen;
  logic [RD_W-1:0]  in_rd;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RD_W-1:0]  out_rd;
  logic             out_wen;

  modport master (
    output in_valid, in_result, in_n, in_z, in_c, in_v, in_set_flags, in_cond, in_wen, in_rd,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_wen,
    output out_ready
  );

  modport slave (
    input  in_valid, in_result, in_n, in_z, in_c, in_v, in_set_flags, in_cond, in_wen, in_rd,
    output in_ready,
    output out_valid, out_result, out_rd, out_wen,
    input  out_ready
  );
endinterface

// File: rtl/alu_flag_stage_cond_eval.sv
// Purely combinational condition-code evaluator against an NZCV vector.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  flag_t      nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_flag_stage.sv
// Flag stage after the ALU: owns NZCV, evaluates each op's condition, annuls
// failed ops' writeback and registers the op toward writeback (one-deep valid/ready).
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_flag_stage_if.slave   bus,
  input  logic              flag_wr,
  input  flag_t             flag_wdata,
  output flag_t             nzcv,
  output logic              cond_pass,
  output logic [CNT_W-1:0]  annul_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  flag_t            nzcv_reg,  nzcv_next;
  logic [CNT_W-1:0] annul_reg, annul_next;
  logic             out_valid_reg;
  logic             out_wen_reg;
  logic [WIDTH-1:0] out_result_reg;
  logic [RD_W-1:0]  out_rd_reg;

  logic  in_ready_w;
  logic  accept;
  logic  pass;
  flag_t alu_flags;

  // No forwarding: the previous op's flags are already committed by the time
  // the next op can be accepted.
  cond_eval u_cond_eval (
    .cond (bus.in_cond),
    .nzcv (nzcv_reg),
    .pass (pass)
  );

  // A direct flag load stalls the input so it never collides with an ALU update.
  assign in_ready_w = !flag_wr && (!out_valid_reg || bus.out_ready);
  assign accept     = bus.in_valid && in_ready_w;
  assign alu_flags  = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};

  always_comb begin
    nzcv_next  = nzcv_reg;
    annul_next = annul_reg;
    if (flag_wr) begin
      nzcv_next = flag_wdata;
    end else if (accept && pass && bus.in_set_flags) begin
      nzcv_next = alu_flags;
    end
    if (accept && !pass && (annul_reg != CNT_MAX)) begin
      annul_next = annul_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nzcv_reg  <= '0;
      annul_reg <= '0;
    end else begin
      nzcv_reg  <= nzcv_next;
      annul_reg <= annul_next;
    end
  end

  // Annulled ops still travel downstream (with wen cleared) to keep retirement in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_wen_reg    <= 1'b0;
      out_result_reg <= '0;
      out_rd_reg     <= '0;
    end else if (accept) begin
      out_valid_reg  <= 1'b1;
      out_wen_reg    <= bus.in_wen && pass;
      out_result_reg <= bus.in_result;
      out_rd_reg     <= bus.in_rd;
    end else if (bus.out_ready) begin
      out_valid_reg  <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_wen    = out_wen_reg;
  assign bus.out_result = out_result_reg;
  assign bus.out_rd     = out_rd_reg;
  assign nzcv           = nzcv_reg;
  assign cond_pass      = pass;
  assign annul_count    = annul_reg;

endmodule

// File: tb/tb_alu_flag_stage.sv
// Scoreboard bench for alu_flag_stage: driver pushes expected retirements from a
// behavioural flag/condition model, a negedge monitor pops and compares them.
module tb_alu_flag_stage;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int RD_W  = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             wen;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flag_wr = 1'b0;
  flag_t            flag_wdata = '0;
  flag_t            nzcv;
  logic             cond_pass;
  logic [CNT_W-1:0] annul_count;

  alu_flag_stage_if #(.WIDTH(WIDTH), .RD_W(RD_W)) bus ();

  alu_flag_stage #(.WIDTH(WIDTH), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .flag_wr     (flag_wr),
    .flag_wdata  (flag_wdata),
    .nzcv        (nzcv),
    .cond_pass   (cond_pass),
    .annul_count (annul_count)
  );

  always #5 clk = ~clk;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_fail = 0;
  flag_t m_nzcv = '0;
  int    m_annul = 0;
  bit    bp_random = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: conditions 0..7 test one flag (odd code = complement);
  // 8..13 are HI/GE/GT with odd codes as their complements; E always, F never.
  function automatic bit ref_pass(input logic [3:0] cond, input flag_t f);
    bit simple[4];
    bit n, z, c, v, hi, ge, gt;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    simple[0] = z; simple[1] = c; simple[2] = n; simple[3] = v;
    hi = c && !z;
    ge = (n == v);
    gt = !z && ge;
    if (cond < 4'd8)  return simple[cond[2:1]] ^ cond[0];
    if (cond == 4'hE) return 1'b1;
    if (cond == 4'hF) return 1'b0;
    if (cond[2:1] == 2'b00) return hi ^ cond[0];
    if (cond[2:1] == 2'b01) return ge ^ cond[0];
    return gt ^ cond[0];
  endfunction

  always @(posedge clk) begin
    #1;
    if (bp_random) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL retire_unexpected: got result 0x%0h with empty scoreboard", bus.out_result);
      end else begin
        mon_e = exp_q.pop_front();
        $display("retire result=0x%08h rd=%0d wen=%0b nzcv=%04b annul=%0d",
                 bus.out_result, bus.out_rd, bus.out_wen, nzcv, annul_count);
        chk("out_result", bus.out_result, mon_e.result);
        chk("out_rd", bus.out_rd, mon_e.rd);
        chk("out_wen", bus.out_wen, mon_e.wen);
      end
    end
  end

  // Presents one op (called just after a rising edge) and returns cycles waited.
  task automatic send(input logic [31:0] res, input logic [3:0] rd, input logic [3:0] cond,
                      input logic wen, input logic setf, input flag_t f, output int waited);
    bit acc;
    bit p;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_result = res;
    bus.in_rd = rd;
    bus.in_cond = cond;
    bus.in_wen = wen;
    bus.in_set_flags = setf;
    {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = f;
    while (!acc) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      else begin
        waited++;
        if (waited > 100) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", waited);
          break;
        end
      end
    end
    if (acc) begin
      p = ref_pass(cond, m_nzcv);
      chk("cond_pass", cond_pass, p);
      exp_q.push_back('{res, rd, wen & p});
      if (p && setf) m_nzcv = f;
      if (!p && m_annul < 255) m_annul++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("nzcv", nzcv, m_nzcv);
    chk("annul_count", annul_count, m_annul);
  endtask

  task automatic do_flag_wr(input flag_t w);
    flag_wr = 1'b1;
    flag_wdata = w;
    @(negedge clk);
    chk("in_ready_during_flag_wr", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    flag_wr = 1'b0;
    m_nzcv = w;
    chk("nzcv_after_flag_wr", nzcv, m_nzcv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] held;
    bus.in_valid = 1'b0;
    bus.in_result = '0;
    bus.in_rd = '0;
    bus.in_cond = '0;
    bus.in_wen = 1'b0;
    bus.in_set_flags = 1'b0;
    {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = 4'b0000;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_out_wen", bus.out_wen, 1'b0);
    chk("reset_out_result", bus.out_result, 32'h0);
    chk("reset_out_rd", bus.out_rd, 4'h0);
    chk("reset_nzcv", nzcv, 4'b0000);
    chk("reset_annul", annul_count, 8'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Flag-setting op, then dependent EQ/NE
    send(32'h0000_0000, 4'd3, 4'hE, 1'b1, 1'b1, 4'b0100, w);
    chk("first_nzcv", nzcv, 4'b0100);
    send(32'h1111_1111, 4'd4, 4'h0, 1'b1, 1'b0, 4'b0000, w);
    send(32'h2222_2222, 4'd5, 4'h1, 1'b1, 1'b1, 4'b1111, w);
    chk("ne_annul_one", annul_count, 8'd1);

    // Signed compare after direct flag load N=1, V=0
    do_flag_wr(4'b1000);
    send(32'h3000_000B, 4'd1, 4'hB, 1'b1, 1'b0, 4'b0000, w);
    send(32'h3000_000A, 4'd2, 4'hA, 1'b1, 1'b0, 4'b0000, w);
    send(32'h3000_000C, 4'd3, 4'hC, 1'b1, 1'b0, 4'b0000, w);
    send(32'h3000_000D, 4'd4, 4'hD, 1'b1, 1'b0, 4'b0000, w);

    // Back-pressure: hold for 3 cycles, then release with no bubble
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    held = 32'hA5A5_5A5A;
    send(held, 4'd9, 4'hE, 1'b1, 1'b0, 4'b0000, w);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 1'b0);
      chk("stall_out_valid", bus.out_valid, 1'b1);
      chk("stall_out_result", bus.out_result, held);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'hC0FF_EE00, 4'd10, 4'hE, 1'b1, 1'b0, 4'b0000, w);
    chk("release_no_bubble", w, 0);

    // Collision of direct flag load with a flag-setting op
    flag_wr = 1'b1;
    flag_wdata = 4'b0010;
    bus.in_valid = 1'b1;
    bus.in_set_flags = 1'b1;
    bus.in_cond = 4'hE;
    @(negedge clk);
    chk("collision_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    flag_wr = 1'b0;
    m_nzcv = 4'b0010;
    chk("collision_nzcv", nzcv, 4'b0010);
    send(32'h0000_0C0C, 4'd6, 4'hE, 1'b1, 1'b1, 4'b1001, w);
    chk("collision_next_cycle", w, 0);

    // Randomised ops under random back-pressure
    bp_random = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) do_flag_wr(4'($urandom));
      send($urandom, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), w);
    end
    bp_random = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Saturation with never-condition ops
    for (int i = 0; i < 300; i++) begin
      send($urandom, 4'($urandom), 4'hF, 1'b1, 1'b1, 4'($urandom), w);
    end
    chk("annul_saturated", annul_count, 8'd255);

    // Asynchronous reset while an op is held
    do_flag_wr(4'b1111);
    bus.out_ready = 1'b0;
    send(32'hDEAD_BEEF, 4'd7, 4'hE, 1'b1, 1'b0, 4'b0000, w);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 1'b0);
    chk("async_rst_nzcv", nzcv, 4'b0000);
    chk("async_rst_annul", annul_count, 8'd0);
    exp_q.delete();
    m_nzcv = '0;
    m_annul = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h0000_0001, 4'd1, 4'h0, 1'b1, 1'b0, 4'b0000, w);
    send(32'h0000_0002, 4'd2, 4'h1, 1'b1, 1'b0, 4'b0000, w);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flag_stage.md
Name: alu_flag_stage

Overview:
- Pipeline stage directly downstream of the bitwise/arithmetic ALU units, e.g. the OR-with-flags unit that produces a 32-bit result plus N/Z (and C/V from the adder units).
- Holds the architectural NZCV flag register and evaluates each op's 4-bit condition code against it.
- Updates flags for flag-setting ops and registers the result toward writeback through a one-deep valid/ready pipeline register.
- Annuls the writeback of ops whose condition fails and counts them.

Parameters:
- WIDTH, 32, result datapath width.
- RD_W, 4, destination register index width.
- CNT_W, 8, width of the saturating annulled-op counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  WIDTH  ALU result.
- in_n, in_z, in_c, in_v  in  1 each  flags computed by the ALU for this op.
- in_set_flags  in  1  op updates NZCV (S suffix).
- in_cond  in  4  condition code.
- in_wen  in  1  op writes a destination register.
- in_rd  in  RD_W  destination index.
- flag_wr  in  1  direct flag load (MSR-style).
- flag_wdata  in  4  {N,Z,C,V} for direct load.
- out_valid  out  1  registered op valid.
- out_ready  in  1  downstream accepts.
- out_result  out  WIDTH  registered result.
- out_rd  out  RD_W  registered destination.
- out_wen  out  1  registered write enable; 0 when annulled.
- nzcv  out  4  current flag register {N,Z,C,V}.
- cond_pass  out  1  combinational condition result for the op currently on in_cond.
- annul_count  out  CNT_W  saturating count of annulled ops.

Behaviour:
- Reset (async, immediate): nzcv=0000, out_valid=0, out_result=0, out_rd=0, out_wen=0, annul_count=0.
- in_ready = !flag_wr && (!out_valid || out_ready). Accept = in_valid && in_ready.
- cond_pass is evaluated combinationally from in_cond and the current nzcv register, with no forwarding. Correctness holds because a prior op's flags are committed on its accept edge, before the next op can be accepted.
- Condition table:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V.
  - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- On accept, the output register loads in_result and in_rd, out_valid=1, and out_wen = in_wen & cond_pass.
- On accept with cond_pass=1 and in_set_flags=1, nzcv <= {in_n,in_z,in_c,in_v} on the same edge.
- On accept with cond_pass=0:
  - nzcv unchanged.
  - Op still travels downstream with out_wen=0, preserving in-order retirement.
  - annul_count increments, saturating at 2^CNT_W-1.
- No accept and out_ready=1: out_valid <= 0; out_result, out_rd and out_wen hold.
- No accept and out_ready=0: output register holds all fields.
- flag_wr=1: nzcv <= flag_wdata. It has priority: in_ready is forced low that cycle, so no accept and no ALU flag update can collide with it.
- Latency is 1 cycle, input accept to out_valid. Full throughput of 1 op/cycle while out_ready=1.
- Back-to-back flag-setting op then conditional op: the second op sees the first op's flags on the cycle after the first is accepted.
- Reset asserted mid-stall drops the held op, with no replay.
- in_* fields are don't-care when in_valid=0. No state changes without an accept, except via flag_wr.

Decomposition:
- Shared package alu_pkg:
  - cond-code constants COND_EQ..COND_NV.
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flag vector typedef (4 bits).
- Sub-module cond_eval: purely combinational, inputs cond[3:0] and nzcv[3:0], output pass. It is reusable by the branch unit.

Test Plan:
- Reset then flag-setting op: in_result=0x00000000, set_flags=1, n=0, z=1, c=0, v=0, cond=E -> next cycle nzcv=0100, out_valid=1, out_wen=in_wen.
- Dependent EQ: with Z=1, op cond=0 in_wen=1 -> out_wen=1; same op with cond=1 (NE) -> out_wen=0, annul_count increments 0->1, nzcv unchanged.
- Signed compare: flag_wr with flag_wdata=1000 (N=1, V=0):
  - cond B (LT) passes, cond A (GE) fails.
  - cond C (GT) fails, cond D (LE) passes.
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_result stable. Release -> next op accepted the same cycle out_ready=1, with no bubble.
- Collision: flag_wr=1 with in_valid=1, set_flags=1 -> in_ready=0, nzcv=flag_wdata, op accepted the following cycle.
- Saturation and NV: 300 ops with cond=F -> all out_wen=0, annul_count=255. Async reset mid-stream -> out_valid=0 and nzcv=0 without a clock edge.
